// File: rtl/sseg_scan.sv
// sseg_scan -- display scan sequencer feeding a seven-segment decoder.
//
// Time-multiplexes six BCD digits (with decimal points and blink masks) onto a
// single {dp, bcd} bus, one position per scan slot of SLOT_CYCLES clocks.
// Inputs are snapshotted once per frame (at the 5->0 position wrap) so a frame
// never tears. A blink phase toggles every BLINK_FRAMES frames.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           display enable; 0 forces blank while scanning continues
//   digits_in    six BCD digits, bits [4k+3:4k] = position k
//   dp_in        decimal point per position (1 = lit)
//   blink_mask   per-position blink enable
//   digit        {dp, bcd} for the current position
//   digit_pos    current position 0..5
//   blank        1 = current position must be dark
//   frame_start  one-cycle pulse in the first cycle of position 0

module sseg_scan #(
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLINK_FRAMES = 83
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [23:0] digits_in,
   input  logic [5:0]  dp_in,
   input  logic [5:0]  blink_mask,
   output logic [4:0]  digit,
   output logic [2:0]  digit_pos,
   output logic        blank,
   output logic        frame_start
);

   localparam int PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SLOT_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [PW-1:0] presc_reg, presc_next;
   logic [2:0]    pos_reg, pos_next;
   logic [23:0]   snap_digits_reg, snap_digits_next;
   logic [5:0]    snap_dp_reg, snap_dp_next;
   logic [5:0]    snap_blink_reg, snap_blink_next;
   logic [BW-1:0] bcnt_reg, bcnt_next;
   logic          phase_reg, phase_next;
   logic [4:0]    digit_reg, digit_next;
   logic          slot_dark_reg, slot_dark_next;
   logic          blank_reg, blank_next;
   logic          fs_reg, fs_next;

   logic          tick;
   logic          frame_wrap;
   logic [23:0]   src_digits;
   logic [5:0]    src_dp;
   logic [5:0]    src_blink;
   logic [3:0]    src_nib [6];
   logic [3:0]    nib;
   logic          nib_bad;

   // Slice the selected digit source into per-position nibbles.
   for (genvar gi = 0; gi < 6; gi++) begin : g_nib
      assign src_nib[gi] = src_digits[4*gi +: 4];
   end

   always_comb begin
      tick       = (presc_reg == PRESC_LAST);
      frame_wrap = tick && (pos_reg == 3'd5);

      presc_next = tick ? '0 : presc_reg + 1'b1;

      pos_next = pos_reg;
      if (tick) begin
         pos_next = (pos_reg == 3'd5) ? 3'd0 : pos_reg + 3'd1;
      end

      // On the wrap edge position 0 is built from the values being captured,
      // so the new frame is visible from its very first cycle.
      src_digits = frame_wrap ? digits_in  : snap_digits_reg;
      src_dp     = frame_wrap ? dp_in      : snap_dp_reg;
      src_blink  = frame_wrap ? blink_mask : snap_blink_reg;

      snap_digits_next = src_digits;
      snap_dp_next     = src_dp;
      snap_blink_next  = src_blink;

      bcnt_next  = bcnt_reg;
      phase_next = phase_reg;
      if (frame_wrap) begin
         if (bcnt_reg == BLINK_LAST) begin
            bcnt_next  = '0;
            phase_next = ~phase_reg;
         end else begin
            bcnt_next = bcnt_reg + 1'b1;
         end
      end

      nib     = src_nib[pos_next];
      nib_bad = (nib > 4'd9);

      digit_next     = digit_reg;
      slot_dark_next = slot_dark_reg;
      if (tick) begin
         digit_next     = {src_dp[pos_next], (nib_bad ? 4'd0 : nib)};
         slot_dark_next = nib_bad | (phase_next & src_blink[pos_next]);
      end

      // en is applied every cycle so blank follows it within one edge.
      blank_next = ~en | slot_dark_next;
      fs_next    = frame_wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_reg       <= '0;
         pos_reg         <= 3'd0;
         snap_digits_reg <= 24'd0;
         snap_dp_reg     <= 6'd0;
         snap_blink_reg  <= 6'd0;
         bcnt_reg        <= '0;
         phase_reg       <= 1'b0;
         digit_reg       <= 5'd0;
         slot_dark_reg   <= 1'b1;   // dark until the first tick
         blank_reg       <= 1'b1;
         fs_reg          <= 1'b0;
      end else begin
         presc_reg       <= presc_next;
         pos_reg         <= pos_next;
         snap_digits_reg <= snap_digits_next;
         snap_dp_reg     <= snap_dp_next;
         snap_blink_reg  <= snap_blink_next;
         bcnt_reg        <= bcnt_next;
         phase_reg       <= phase_next;
         digit_reg       <= digit_next;
         slot_dark_reg   <= slot_dark_next;
         blank_reg       <= blank_next;
         fs_reg          <= fs_next;
      end
   end

   assign digit       = digit_reg;
   assign digit_pos   = pos_reg;
   assign blank       = blank_reg;
   assign frame_start = fs_reg;

endmodule

// File: tb/tb_sseg_scan.sv
// tb_sseg_scan -- self-checking bench for sseg_scan with SLOT_CYCLES=4 and
// BLINK_FRAMES=2. Frame vectors hold the inputs to be captured at a frame
// boundary and the six expected {digit, blank} slot values; those slot values
// go into a scoreboard queue when the inputs are driven and are popped as each
// slot appears. Every cycle is checked for position, digit, blank and
// frame_start. Enable drop and mid-frame reset are hand-written sequences.

module tb_sseg_scan;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [23:0] digits_in;
   logic [5:0]  dp_in;
   logic [5:0]  blink_mask;
   logic [4:0]  digit;
   logic [2:0]  digit_pos;
   logic        blank;
   logic        frame_start;

   sseg_scan #(.SLOT_CYCLES(4), .BLINK_FRAMES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .blink_mask  (blink_mask),
      .digit       (digit),
      .digit_pos   (digit_pos),
      .blank       (blank),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] d;
      logic       b;
   } slot_t;

   typedef struct {
      logic [23:0] digits;
      logic [5:0]  dp;
      logic [5:0]  bm;
      logic [23:0] mid;        // live digits applied mid-frame while this frame shows
      logic [29:0] exp_digit;  // {pos5, ..., pos0}, 5 bits each
      logic [5:0]  exp_blank;  // bit k = expected slot blank for position k
   } vec_t;

   localparam int NV = 10;
   vec_t  vecs [NV];
   slot_t sb [$];

   int   n_tests;
   int   n_fail;
   int   k;        // clock edges since reset release
   logic en_s;     // en as seen by the DUT at the last edge
   logic [4:0] cur_d;
   logic       cur_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s k=%0d: got %0h, expected %0h", name, k, act, exp);
      end
   endtask

   task automatic push_frame(input logic [29:0] ed, input logic [5:0] eb);
      for (int p = 0; p < 6; p++) begin
         sb.push_back('{d: ed[5*p +: 5], b: eb[p]});
      end
   endtask

   // Slots 1..5 of the first frame after reset show the cleared snapshot.
   task automatic push_reset_frame();
      for (int p = 1; p < 6; p++) begin
         sb.push_back('{d: 5'h00, b: 1'b0});
      end
   endtask

   task automatic check_cycle();
      slot_t s;
      if (k > 0 && (k % 4) == 0) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty k=%0d: got no expectation, required one", k);
         end else begin
            s     = sb.pop_front();
            cur_d = s.d;
            cur_b = s.b;
         end
      end
      chk("digit_pos",   {29'd0, digit_pos},   32'((k / 4) % 6));
      chk("digit",       {27'd0, digit},       {27'd0, cur_d});
      chk("blank",       {31'd0, blank},       {31'd0, cur_b | ~en_s});
      chk("frame_start", {31'd0, frame_start}, (k > 0 && (k % 24) == 0) ? 32'd1 : 32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      en_s = en;
      #1;
      k++;
      check_cycle();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_digit"},       {27'd0, digit},       32'd0);
      chk({tag, "_digit_pos"},   {29'd0, digit_pos},   32'd0);
      chk({tag, "_blank"},       {31'd0, blank},       32'd1);
      chk({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      k          = 0;
      en_s       = 1'b1;
      cur_d      = 5'd0;
      cur_b      = 1'b1;
      rst_n      = 1'b0;
      en         = 1'b1;
      digits_in  = 24'd0;
      dp_in      = 6'd0;
      blink_mask = 6'd0;

      vecs[0] = '{24'h123456, 6'b000000, 6'b000000, 24'h999999,
                  {5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06}, 6'b000000};
      vecs[1] = '{24'h000090, 6'b000100, 6'b000000, 24'h999999,
                  {5'h00, 5'h00, 5'h00, 5'h10, 5'h09, 5'h00}, 6'b000000};
      vecs[2] = '{24'h111111, 6'b000000, 6'b000000, 24'h222222,
                  {5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01}, 6'b000000};
      vecs[3] = '{24'h222222, 6'b000000, 6'b000000, 24'h999999,
                  {5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02}, 6'b000000};
      // Blink frames 6..9: phase is 0,1,1,0 (toggles every second frame).
      vecs[4] = '{24'h012345, 6'b000000, 6'b000001, 24'h999999,
                  {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05}, 6'b000000};
      vecs[5] = '{24'h012345, 6'b000000, 6'b000001, 24'h999999,
                  {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05}, 6'b000001};
      vecs[6] = '{24'h012345, 6'b000000, 6'b000001, 24'h999999,
                  {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05}, 6'b000001};
      vecs[7] = '{24'h012345, 6'b000000, 6'b000001, 24'h999999,
                  {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05}, 6'b000000};
      // Invalid BCD at position 4 (with its dp lit): digit 5'h10, blank.
      vecs[8] = '{24'h0B1234, 6'b010000, 6'b000000, 24'h999999,
                  {5'h00, 5'h10, 5'h01, 5'h02, 5'h03, 5'h04}, 6'b010000};
      vecs[9] = '{24'h555555, 6'b000000, 6'b000000, 24'h999999,
                  {5'h05, 5'h05, 5'h05, 5'h05, 5'h05, 5'h05}, 6'b000000};

      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");

      // Release and scan the table, one frame per vector.
      rst_n = 1'b1;
      k     = 0;
      push_reset_frame();
      check_cycle();
      for (int i = 0; i < NV; i++) begin
         for (int c = 0; c < 24; c++) begin
            if (c == 12 && i > 0) digits_in = vecs[i-1].mid;
            if (c == 20) begin
               digits_in  = vecs[i].digits;
               dp_in      = vecs[i].dp;
               blink_mask = vecs[i].bm;
               push_frame(vecs[i].exp_digit, vecs[i].exp_blank);
            end
            step();
         end
      end

      // Enable dropped for three edges in the middle of slot 2, spanning a tick.
      while (k < 249) step();
      en = 1'b0;
      repeat (3) step();
      en = 1'b1;
      while (k < 260) step();
      digits_in  = 24'h876543;
      dp_in      = 6'b100000;
      blink_mask = 6'b000000;
      push_frame({5'h18, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03}, 6'b000000);

      // Reset asserted mid-slot while position 4 is showing.
      while (k < 281) step();
      rst_n = 1'b0;
      #1;
      chk_reset("midreset");
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_reset("midreset_hold");

      // Blink phase was 1 before reset; after reset position 0 must be visible.
      digits_in  = 24'h000007;
      dp_in      = 6'b000000;
      blink_mask = 6'b000001;
      sb.delete();
      cur_d = 5'd0;
      cur_b = 1'b1;
      en_s  = 1'b1;
      rst_n = 1'b1;
      k     = 0;
      push_reset_frame();
      check_cycle();
      while (k < 20) step();
      push_frame({5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h07}, 6'b000000);
      while (k < 28) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
